// File: rtl/msrv32_pc_gen.sv
// Program-counter generator: picks the next fetch address (trap, mret, branch or sequential),
// holds the architectural PC, and buffers redirects that arrive while the fetch port is stalled.
module msrv32_pc_gen #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        instr_valid_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        ahb_ready_in,
    output logic [31:0] i_addr_out,
    output logic        imem_req_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        misaligned_instr_out,
    output logic [31:0] misaligned_tval_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pend_addr;
    logic [31:0] tgt;
    logic        branch_req;
    logic        branch_ok;
    logic        misaligned;
    logic        redirect;
    logic [31:0] run_addr;

    assign tgt           = {iadder_in[31:1], 1'b0};
    assign pc_plus_4_out = pc_out + 32'd4;
    assign branch_req    = instr_valid_in & branch_taken_in;

    // A misaligned branch only counts when it would actually have won arbitration.
    assign misaligned = (state == RUN) & ~trap_taken_in & ~mret_in & branch_req & tgt[1];
    assign branch_ok  = branch_req & ~tgt[1];
    assign redirect   = trap_taken_in | mret_in | branch_ok;

    always_comb begin
        run_addr = pc_plus_4_out;
        if (trap_taken_in)
            run_addr = trap_address_in;
        else if (mret_in)
            run_addr = epc_in;
        else if (branch_ok)
            run_addr = tgt;
    end

    always_comb begin
        i_addr_out = BOOT_ADDRESS;
        case (state)
            RUN:     i_addr_out = run_addr;
            HOLD:    i_addr_out = pend_addr;
            default: i_addr_out = BOOT_ADDRESS;
        endcase
    end

    // Fetch is requested whenever the core is out of reset.
    assign imem_req_out         = rst_n_in;
    assign misaligned_instr_out = misaligned;
    assign state_out            = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= BOOT;
            pc_out              <= BOOT_ADDRESS;
            pend_addr           <= 32'd0;
            misaligned_tval_out <= 32'd0;
        end else begin
            if (misaligned)
                misaligned_tval_out <= tgt;
            case (state)
                BOOT: begin
                    if (ahb_ready_in) begin
                        pc_out <= BOOT_ADDRESS;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (ahb_ready_in) begin
                        pc_out <= run_addr;
                    end else if (redirect) begin
                        pend_addr <= run_addr;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (trap_taken_in)
                        pend_addr <= trap_address_in;
                    if (ahb_ready_in) begin
                        pc_out <= pend_addr;
                        state  <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
